// File: rtl/andor_exerciser_if.sv
// andor_exerciser_if: control, status and gate-side pins of the AND/OR gate exerciser.
interface andor_exerciser_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;
    modport master (
        input  start, x, y,
        output a, b, c, busy, done, pass, err_count, first_fail
    );
    modport slave (
        output start, x, y,
        input  a, b, c, busy, done, pass, err_count, first_fail
    );
endinterface

// File: rtl/andor_exerciser.sv
// andor_exerciser: sweeps A/B/C over all 8 vectors, checks X = A & B, Y = B | C after a settle delay.
// Define ANDOR_EXERCISER_HALT_ON_ERR_EN to end the run at the first mismatch.
module andor_exerciser #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input logic clk_i,
    input logic rst_i,
    andor_exerciser_if.master bus
);
`ifdef ANDOR_EXERCISER_HALT_ON_ERR_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    state_t     state_q, state_d;
    logic [2:0] vec_q, vec_d, abc_q, abc_d, ff_q, ff_d;
    logic [3:0] set_q, set_d, err_q, err_d;
    logic [7:0] loop_q, loop_d;
    logic       busy_q, done_q, pass_q, pass_d;
    logic       mism, last_loop;
    // Expected values come from our own registered stimulus, not from the gate.
    assign mism      = (bus.x != (abc_q[2] & abc_q[1])) || (bus.y != (abc_q[1] | abc_q[0]));
    assign last_loop = (loop_q + 8'd1) >= 8'(LOOPS);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            vec_q   <= '0;
            abc_q   <= '0;
            ff_q    <= '0;
            set_q   <= '0;
            err_q   <= '0;
            loop_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            abc_q   <= abc_d;
            ff_q    <= ff_d;
            set_q   <= set_d;
            err_q   <= err_d;
            loop_q  <= loop_d;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
            pass_q  <= pass_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? DRIVE : IDLE;
            DRIVE:   state_d = SETTLE;
            SETTLE:  state_d = (set_q == 4'(SETTLE_CYCLES - 1)) ? CHECK : SETTLE;
            CHECK:   state_d = ((HALT && mism) || (vec_q == 3'd7 && last_loop)) ? DONE : DRIVE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        vec_d  = vec_q;
        abc_d  = abc_q;
        ff_d   = ff_q;
        set_d  = set_q;
        err_d  = err_q;
        loop_d = loop_q;
        pass_d = pass_q;
        if (state_q == IDLE && bus.start) begin
            vec_d  = '0;
            loop_d = '0;
            err_d  = '0;
            ff_d   = '0;
            pass_d = 1'b0;
        end
        if (state_q == DRIVE) begin
            abc_d = vec_q;
            set_d = '0;
        end
        if (state_q == SETTLE) set_d = set_q + 4'd1;
        if (state_q == CHECK) begin
            err_d  = mism ? ((err_q == 4'd15) ? err_q : err_q + 4'd1) : err_q;
            ff_d   = (mism && err_q == 4'd0) ? vec_q : ff_q;
            vec_d  = (HALT && mism) ? vec_q : vec_q + 3'd1;
            loop_d = (!(HALT && mism) && vec_q == 3'd7) ? loop_q + 8'd1 : loop_q;
        end
        if (state_d == DONE) pass_d = err_d == 4'd0;
    end
    assign bus.a          = abc_q[2];
    assign bus.b          = abc_q[1];
    assign bus.c          = abc_q[0];
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.first_fail = ff_q;
endmodule

// File: doc/andor_exerciser.md
# andor_exerciser

Self-checking exerciser for the two-output AND/OR gate block (X = A & B, Y = B | C).
- Drives the gate's A/B/C inputs through all 8 input combinations and samples its X/Y outputs after a programmable settle interval.
- Compares each sample against the expected logic function and reports the result.
- Sits beside the gate in lab benches and board-level self-test, as its counterpart: it drives the gate's inputs and reads its outputs.

## Interface
- SETTLE_CYCLES, 2, wait cycles between driving a vector and sampling X/Y; legal 1..15; covers the gate's 10-unit propagation delay.
- LOOPS, 1, full 8-vector sweeps per Start; legal 1..255.
- Clk  input  1  rising-edge clock, the only clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request to begin a run; honoured only in IDLE.
- A, B, C  output  1 each  registered stimulus to the gate; A = vec[2], B = vec[1], C = vec[0].
- X, Y  input  1 each  gate outputs under test.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle pulse when a run completes.
- Pass  output  1  valid from Done until the next Start; 1 when ErrCount == 0.
- ErrCount  output  4  mismatching vectors in the last run; saturates at 15.
- FirstFail  output  3  vec value of the first mismatch in the run; 0 if none.

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK, DONE.
- Reset forces IDLE from any state, mid-run included, and zeroes every output: A/B/C, Busy, Done, Pass, ErrCount, FirstFail and all internal counters.
- IDLE:
  - Start=1 clears ErrCount, FirstFail, Pass, vec and the loop counter, then goes to DRIVE.
  - Start while Busy is ignored.
- DRIVE (1 cycle): A/B/C take the current vec; go to SETTLE with the settle counter = 0.
- SETTLE: the settle counter increments each cycle; after SETTLE_CYCLES cycles, go to CHECK.
- CHECK (1 cycle):
  - Expected values are expX = A & B and expY = B | C.
  - A mismatch is X != expX or Y != expY.
  - On a mismatch, ErrCount increments (saturating at 15). FirstFail is captured only on the first mismatch of the run.
  - If vec < 7: vec increments and the FSM goes to DRIVE.
  - If vec == 7: vec wraps to 0 and the loop counter increments. The FSM goes to DRIVE if the loop counter < LOOPS, otherwise to DONE.
- DONE (1 cycle):
  - Done = 1 and Pass = (ErrCount == 0).
  - Go to IDLE.
  - A/B/C, ErrCount, FirstFail and Pass hold until the next Start or Reset.
- A Start that arrives during DONE is ignored; a Start in the following IDLE cycle is accepted.

## Timing
- Start sampled high in IDLE at edge n: DRIVE in cycle n+1, and A/B/C show vec 0 from edge n+2.
- Per vector: 2 + SETTLE_CYCLES cycles.
- Run length: LOOPS × 8 × (2 + SETTLE_CYCLES) cycles from DRIVE entry to DONE entry. Default is 32 cycles.
- Done pulses in the cycle immediately after the last CHECK; Busy falls in the same cycle as the Done pulse's falling edge, i.e. on IDLE entry.
- X/Y are sampled only at the edge ending CHECK; values in other cycles are don't-care.
- All outputs are registered; there is no combinational path from X/Y to any output.

## Configuration
- Macro: ANDOR_EXERCISER_HALT_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes straight to DONE. ErrCount = 1, Pass = 0, and FirstFail holds the failing vec. Remaining vectors and loops are skipped.
- Undefined: every vector of every loop is always checked; behaviour is as described under Operation.

## Test plan
- Correct gate model (X = A & B, Y = B | C, 1-cycle lag), defaults, Start pulse -> Done at cycle 33 after Start; Pass = 1, ErrCount = 0, FirstFail = 0.
- X stuck at 0 -> vectors 6 and 7 fail; ErrCount = 2, FirstFail = 6, Pass = 0.
- Y inverted, LOOPS = 3 -> 24 mismatches; ErrCount saturates at 15 and Done pulses at cycle 97.
- Reset asserted in cycle 10 of a run -> next cycle IDLE with A/B/C/Busy/ErrCount = 0. A new Start then completes normally with Pass = 1.
- Start held high through a run and pulsed again during DONE -> a single run only; the second run starts only on a Start sampled in IDLE.
- With ANDOR_EXERCISER_HALT_ON_ERR_EN and Y stuck at 1 -> fails at vec 0; Done at cycle 5 after Start, ErrCount = 1, FirstFail = 0, Pass = 0.
